// File: rtl/y86_wb_trace_logger_if.sv
// Trace-record stream between the write-back logger and its downstream consumer.
// Carries one packed retirement record per valid/ready transfer.
interface y86_wb_trace_logger_if #(
    parameter int SEQ_W = 16
);
    // {seq, icode, stat, dstE, dstM, valE, valM}
    localparam int REC_W = SEQ_W + 142;

    logic             out_valid;
    logic             out_ready;
    logic [REC_W-1:0] out_rec;

    modport master (output out_valid, output out_rec, input out_ready);
    modport slave  (input out_valid, input out_rec, output out_ready);
endinterface

// File: rtl/y86_wb_trace_logger.sv
// Write-back retirement logger: packs every retired non-bubble instruction into
// a sequence-numbered record, buffers it in a FIFO and drains it over valid/ready.
// A non-AOK retirement freezes capture so the trace ends on the faulting record.
module y86_wb_trace_logger #(
    parameter int         DEPTH  = 16,
    parameter int         SEQ_W  = 16,
    parameter logic [3:0] NOP_IC = 4'h1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      cap_en,
    input  logic [3:0]                W_icode,
    input  logic [1:0]                W_stat,
    input  logic [3:0]                W_dstE,
    input  logic [3:0]                W_dstM,
    input  logic [63:0]               W_valE,
    input  logic [63:0]               W_valM,
    input  logic                      W_stall,
    y86_wb_trace_logger_if.master     trc,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      frozen,
    output logic                      overflow,
    output logic [15:0]               drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [3:0]       icode;
        logic [1:0]       stat;
        logic [3:0]       dst_e;
        logic [3:0]       dst_m;
        logic [63:0]      val_e;
        logic [63:0]      val_m;
    } rec_t;

    typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_t;

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [SEQ_W-1:0] seq;
    state_t           state_q, state_d;

    logic full, qual, pop, push, drop;
    rec_t new_rec;

    // Capture qualification and FIFO handshake decode.
    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        pop     = trc.out_valid & trc.out_ready;
        qual    = cap_en & ~frozen & ~W_stall & (W_icode != NOP_IC);
        // A pop frees the slot on the same edge, so a full FIFO can still accept.
        push    = qual & (~full | pop);
        drop    = qual & full & ~pop;
        new_rec = '{seq: seq, icode: W_icode, stat: W_stat, dst_e: W_dstE,
                    dst_m: W_dstM, val_e: W_valE, val_m: W_valM};
    end

    // Freeze FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Freeze FSM next state: any non-AOK qualifying record (pushed or dropped) ends capture.
    always_comb begin
        state_d = state_q;
        if (clr)
            state_d = RUN;
        else if (state_q == RUN && qual && W_stat != 2'b00)
            state_d = FROZEN;
    end

    // Freeze FSM outputs.
    always_comb begin
        frozen = (state_q == FROZEN);
    end

    // Record storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= new_rec;
    end

    // Pointers, occupancy and sequence number; clr overrides every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            seq    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            seq    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                seq    <= seq + SEQ_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Head of FIFO drives the stream; it only moves on a pop, so it is stable under backpressure.
    always_comb begin
        trc.out_valid = (count != '0);
        trc.out_rec   = mem[rd_ptr];
    end
endmodule

// File: tb/tb_y86_wb_trace_logger.sv
// Directed testbench for the write-back trace logger.
module tb_y86_wb_trace_logger;
    localparam int DEPTH = 16;
    localparam int SEQ_W = 16;
    localparam int REC_W = SEQ_W + 142;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, cap_en, W_stall;
    logic [3:0]  W_icode, W_dstE, W_dstM;
    logic [1:0]  W_stat;
    logic [63:0] W_valE, W_valM;
    logic [4:0]  count;
    logic        frozen, overflow;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    y86_wb_trace_logger_if #(.SEQ_W(SEQ_W)) trc ();

    y86_wb_trace_logger #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .NOP_IC(4'h1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cap_en(cap_en),
        .W_icode(W_icode), .W_stat(W_stat), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .W_valE(W_valE), .W_valM(W_valM), .W_stall(W_stall), .trc(trc),
        .count(count), .frozen(frozen), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [REC_W-1:0] exp_rec(input logic [SEQ_W-1:0] s, input logic [3:0] ic,
                                                 input logic [1:0] st, input logic [3:0] de,
                                                 input logic [3:0] dm, input logic [63:0] ve,
                                                 input logic [63:0] vm);
        return {s, ic, st, de, dm, ve, vm};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [1:0] st, input logic [63:0] ve);
        W_icode = ic;
        W_stat  = st;
        W_dstE  = 4'h3;
        W_dstM  = 4'hF;
        W_valE  = ve;
        W_valM  = ~ve;
    endtask

    task automatic do_clr;
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset;
        total++; if (trc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", trc.out_valid); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if ({frozen, overflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {frozen, overflow}); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    endtask

    task automatic test_basic;
        logic [3:0] ics [3];
        ics[0] = 4'h2; ics[1] = 4'h3; ics[2] = 4'h6;
        do_clr();
        trc.out_ready = 1'b1;
        cap_en = 1'b1;
        drive(ics[0], 2'b00, 64'hA0);
        #1;
        total++; if (trc.out_valid !== 1'b0) begin bad++; $display("FAIL basic_no_bypass got=%b exp=0", trc.out_valid); end
        for (int i = 0; i < 3; i++) begin
            drive(ics[i], 2'b00, 64'hA0 + 64'(i));
            step();
            total++;
            if (trc.out_valid !== 1'b1 || trc.out_rec !== exp_rec(SEQ_W'(i), ics[i], 2'b00, 4'h3, 4'hF, 64'hA0 + 64'(i), ~(64'hA0 + 64'(i)))) begin
                bad++; $display("FAIL basic_rec%0d got=%b/%h exp=1/%h", i, trc.out_valid, trc.out_rec,
                                exp_rec(SEQ_W'(i), ics[i], 2'b00, 4'h3, 4'hF, 64'hA0 + 64'(i), ~(64'hA0 + 64'(i))));
            end
        end
        drive(4'h1, 2'b00, 64'hDEAD);
        step();
        total++; if (trc.out_valid !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL basic_nop got=%b/%0d exp=0/0", trc.out_valid, count); end
        cap_en = 1'b0;
    endtask

    task automatic test_overflow;
        do_clr();
        trc.out_ready = 1'b0;
        cap_en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive(4'h6, 2'b00, 64'h1000 + 64'(i));
            step();
        end
        cap_en = 1'b0;
        total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
        total++; if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_drop got=%b/%0d exp=1/2", overflow, drop_cnt); end
        trc.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (trc.out_valid !== 1'b1 || trc.out_rec !== exp_rec(SEQ_W'(i), 4'h6, 2'b00, 4'h3, 4'hF, 64'h1000 + 64'(i), ~(64'h1000 + 64'(i)))) begin
                bad++; $display("FAIL ovf_drain%0d got=%b/%h", i, trc.out_valid, trc.out_rec);
            end
            step();
        end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL ovf_empty got=%0d exp=0", count); end
        trc.out_ready = 1'b0;
        cap_en = 1'b1;
        drive(4'h6, 2'b00, 64'h5555);
        step();
        cap_en = 1'b0;
        total++; if (trc.out_rec !== exp_rec(SEQ_W'(16), 4'h6, 2'b00, 4'h3, 4'hF, 64'h5555, ~64'h5555)) begin
            bad++; $display("FAIL ovf_next_seq got=%h exp_seq=16", trc.out_rec);
        end
    endtask

    task automatic test_full_push_pop;
        do_clr();
        trc.out_ready = 1'b0;
        cap_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(4'h6, 2'b00, 64'h2000 + 64'(i));
            step();
        end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL fpp_fill got=%0d exp=16", count); end
        trc.out_ready = 1'b1;
        drive(4'h6, 2'b00, 64'h2010);
        step();
        cap_en = 1'b0;
        total++; if (count !== 5'd16 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL fpp_both got=%0d/%0d/%b exp=16/0/0", count, drop_cnt, overflow);
        end
        for (int i = 1; i <= 16; i++) begin
            total++;
            if (trc.out_rec !== exp_rec(SEQ_W'(i), 4'h6, 2'b00, 4'h3, 4'hF, 64'h2000 + 64'(i), ~(64'h2000 + 64'(i)))) begin
                bad++; $display("FAIL fpp_drain%0d got=%h", i, trc.out_rec);
            end
            step();
        end
        total++; if (trc.out_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%b exp=0", trc.out_valid); end
        trc.out_ready = 1'b0;
    endtask

    task automatic test_freeze;
        do_clr();
        trc.out_ready = 1'b0;
        cap_en = 1'b1;
        drive(4'h0, 2'b01, 64'h0);
        step();
        total++; if (frozen !== 1'b1 || count !== 5'd1) begin bad++; $display("FAIL frz_set got=%b/%0d exp=1/1", frozen, count); end
        drive(4'h6, 2'b00, 64'h77);
        step();
        total++; if (count !== 5'd1) begin bad++; $display("FAIL frz_block got=%0d exp=1", count); end
        total++; if (trc.out_rec !== exp_rec(SEQ_W'(0), 4'h0, 2'b01, 4'h3, 4'hF, 64'h0, ~64'h0)) begin
            bad++; $display("FAIL frz_rec got=%h", trc.out_rec);
        end
        do_clr();
        total++; if (frozen !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL frz_clr got=%b/%0d exp=0/0", frozen, count); end
        // clr must beat a simultaneous qualifying push
        clr = 1'b1;
        drive(4'h6, 2'b00, 64'h88);
        step();
        clr = 1'b0;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL clr_wins got=%0d exp=0", count); end
        drive(4'h6, 2'b00, 64'h99);
        step();
        cap_en = 1'b0;
        total++; if (trc.out_rec !== exp_rec(SEQ_W'(0), 4'h6, 2'b00, 4'h3, 4'hF, 64'h99, ~64'h99)) begin
            bad++; $display("FAIL clr_seq0 got=%h", trc.out_rec);
        end
    endtask

    task automatic test_stall;
        do_clr();
        trc.out_ready = 1'b0;
        cap_en = 1'b1;
        W_stall = 1'b1;
        drive(4'h6, 2'b00, 64'h42);
        repeat (3) step();
        total++; if (count !== 5'd0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", count); end
        W_stall = 1'b0;
        step();
        cap_en = 1'b0;
        step();
        total++; if (count !== 5'd1) begin bad++; $display("FAIL stall_release got=%0d exp=1", count); end
        total++; if (trc.out_rec !== exp_rec(SEQ_W'(0), 4'h6, 2'b00, 4'h3, 4'hF, 64'h42, ~64'h42)) begin
            bad++; $display("FAIL stall_rec got=%h", trc.out_rec);
        end
    endtask

    task automatic test_async_reset;
        do_clr();
        trc.out_ready = 1'b0;
        cap_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(4'h6, 2'b00, 64'h300 + 64'(i));
            step();
        end
        cap_en = 1'b0;
        total++; if (count !== 5'd5) begin bad++; $display("FAIL arst_pre got=%0d exp=5", count); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (trc.out_valid !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL arst_now got=%b/%0d exp=0/0", trc.out_valid, count); end
        step();
        rst_n = 1'b1;
        cap_en = 1'b1;
        drive(4'h6, 2'b00, 64'h400);
        step();
        cap_en = 1'b0;
        total++; if (trc.out_rec !== exp_rec(SEQ_W'(0), 4'h6, 2'b00, 4'h3, 4'hF, 64'h400, ~64'h400)) begin
            bad++; $display("FAIL arst_seq0 got=%h", trc.out_rec);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr = 1'b0;
        cap_en = 1'b0;
        W_stall = 1'b0;
        trc.out_ready = 1'b0;
        drive(4'h1, 2'b00, 64'h0);
        repeat (2) step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_freeze();
        test_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
